// File: rtl/uart_echo_fifo.sv
// RS-232 echo core: a receiver feeds an elastic FIFO that a transmitter drains
// back out to the line. Everything runs in the clk domain.
module uart_echo_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          RXd,
  input  logic                          tx_hold,
  output logic                          TXd,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  // state    | meaning
  // S_IDLE   | RX: waiting for a falling edge; TX: waiting for data and !tx_hold
  // S_START  | start bit (RX rejects a high mid-bit sample as a glitch)
  // S_DATA   | data bits, LSB first
  // S_PAR    | parity bit, only visited when PARITY != 0
  // S_STOP   | stop bit(s); RX resolves the byte at the first stop sample
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT  = CW'(CLKS_PER_BIT / 2);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_LVL  = (AW+1)'(FIFO_DEPTH);

  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {rx_meta, rx_sync, rx_prev} <= 3'b111;
    else      {rx_meta, rx_sync, rx_prev} <= {RXd, rx_meta, rx_sync};
  end

  state_t               rx_state, rx_next;
  logic [CW-1:0]        rx_cnt;
  logic [2:0]           rx_idx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_pbit, rx_tick, stop_sample, par_ok;
  logic                 push, push_ok, pop, full;

  assign rx_tick     = (rx_cnt == '0);
  assign stop_sample = (rx_state == S_STOP) && rx_tick;
  assign par_ok      = (PARITY == 0) || ((^rx_data ^ rx_pbit) == (PARITY == 1));
  assign push        = stop_sample && rx_sync && par_ok;

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      S_IDLE:  if (rx_prev && !rx_sync) rx_next = S_START;
      S_START: if (rx_tick) rx_next = rx_sync ? S_IDLE : S_DATA;
      S_DATA:  if (rx_tick && rx_idx == DATA_LAST) rx_next = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (rx_tick) rx_next = S_STOP;
      S_STOP:  if (rx_tick) rx_next = S_IDLE;
      default: rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= S_IDLE;
      rx_cnt   <= HALF_BIT;
      rx_idx   <= '0;
      rx_data  <= '0;
      rx_pbit  <= 1'b0;
    end else begin
      rx_state <= rx_next;
      // Half-bit preload puts every later sample near mid-bit.
      if (rx_state == S_IDLE) rx_cnt <= HALF_BIT;
      else if (rx_tick)       rx_cnt <= BIT_LAST;
      else                    rx_cnt <= rx_cnt - 1'b1;
      if (rx_state == S_START) rx_idx <= '0;
      if (rx_state == S_DATA && rx_tick) begin
        rx_data <= {rx_sync, rx_data[DATA_BITS-1:1]};
        rx_idx  <= rx_idx + 1'b1;
      end
      if (rx_state == S_PAR && rx_tick) rx_pbit <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= stop_sample && !rx_sync;
      parity_err <= stop_sample && rx_sync && !par_ok;
      overrun    <= push && full && !pop;
    end
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;

  assign full    = (fifo_level == FULL_LVL);
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push_ok) fifo_level <= fifo_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_data;
  end

  state_t               tx_state, tx_next;
  logic [CW-1:0]        tx_cnt;
  logic [2:0]           tx_idx;
  logic                 tx_stop_idx, tx_pbit, tx_tick, tx_line;
  logic [DATA_BITS-1:0] tx_shift;

  assign tx_tick = (tx_cnt == '0);
  assign pop     = (tx_state == S_IDLE) && (fifo_level != '0) && !tx_hold;

  always_comb begin
    tx_next = tx_state;
    tx_line = 1'b1;
    unique case (tx_state)
      S_IDLE:  if (pop) tx_next = S_START;
      S_START: begin
        tx_line = 1'b0;
        if (tx_tick) tx_next = S_DATA;
      end
      S_DATA: begin
        tx_line = tx_shift[0];
        if (tx_tick && tx_idx == DATA_LAST) tx_next = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: begin
        tx_line = tx_pbit;
        if (tx_tick) tx_next = S_STOP;
      end
      S_STOP:  if (tx_tick && tx_stop_idx == STOP_LAST) tx_next = S_IDLE;
      default: tx_next = S_IDLE;
    endcase
  end

  // TXd is the line value of the previous cycle's state, so every bit keeps
  // its full width and the output stays glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state    <= S_IDLE;
      TXd         <= 1'b1;
      tx_cnt      <= BIT_LAST;
      tx_idx      <= '0;
      tx_stop_idx <= 1'b0;
      tx_shift    <= '0;
      tx_pbit     <= 1'b0;
    end else begin
      tx_state <= tx_next;
      TXd      <= tx_line;
      if (tx_state == S_IDLE || tx_tick) tx_cnt <= BIT_LAST;
      else                               tx_cnt <= tx_cnt - 1'b1;
      if (pop) begin
        tx_shift    <= mem[rd_ptr];
        tx_pbit     <= ^mem[rd_ptr] ^ (PARITY == 1);
        tx_idx      <= '0;
        tx_stop_idx <= 1'b0;
      end
      if (tx_state == S_DATA && tx_tick) begin
        tx_shift <= tx_shift >> 1;
        tx_idx   <= tx_idx + 1'b1;
      end
      if (tx_state == S_STOP && tx_tick) tx_stop_idx <= tx_stop_idx + 1'b1;
    end
  end

endmodule

// File: doc/uart_echo_fifo.md
# uart_echo_fifo

Parametrised RS-232 echo core with a receiver, a transmitter and an elastic FIFO in one clock domain. It supersedes the fixed 10-bit receiver/transmitter pair. Adds:
- configurable data width, parity, stop bits and baud divisor;
- a buffered path, so back-to-back frames are not lost while the transmitter is busy;
- error reporting;
- transmit flow control.

Sits directly on the board UART pins.

## Interface
- CLKS_PER_BIT, default 868: clk cycles per serial bit (100 MHz / 115200); legal values ≥ 4.
- DATA_BITS, default 8: data bits per frame, 5..8, sent LSB first.
- PARITY, default 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, default 1: stop bits generated by TX, 1 or 2. RX checks only the first.
- FIFO_DEPTH, default 16: entries, power of two, ≥ 2.
- clk  input  1  system clock; single clock domain.
- rst  input  1  reset; asynchronous, active-low.
- RXd  input  1  serial receive line; idle high; asynchronous to clk.
- tx_hold  input  1  while 1, TX starts no new frame; a frame in progress completes.
- TXd  output  1  serial transmit line; idle high.
- parity_err  output  1  one-cycle pulse: received byte failed parity and was discarded.
- frame_err  output  1  one-cycle pulse: first stop bit sampled 0; byte discarded.
- overrun  output  1  one-cycle pulse: good byte arrived with FIFO full and was dropped.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  entries currently stored, 0..FIFO_DEPTH.

## Operation
- Reset (rst low, immediate):
  - TXd = 1; parity_err = frame_err = overrun = 0; fifo_level = 0.
  - Both FSMs go to IDLE; FIFO is emptied.
  - Reset mid-frame aborts the frame with no partial byte stored or sent.
- RX sync: RXd passes through a 2-flop synchroniser, reset value 1. All RX decisions use the synchronised value.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START on a synchronised falling edge. The bit counter is loaded with CLKS_PER_BIT/2.
  - START: at mid-bit, if the line is high, treat it as a glitch and return to IDLE. Otherwise go to DATA.
  - DATA: samples DATA_BITS bits, each a full CLKS_PER_BIT after the previous sample. Then goes to PARITY (if PARITY ≠ 0) or STOP.
  - PARITY: samples one bit and checks it against the XOR of the data bits (odd/even as configured).
  - STOP: samples the first stop bit, resolves the byte in that cycle, then returns to IDLE. The next start edge is therefore accepted from mid-stop-bit onward.
- Byte resolution, evaluated in the stop-sample cycle, in priority order:
  1. frame_err if the stop bit is 0.
  2. Otherwise parity_err if the parity check fails.
  3. Otherwise push to the FIFO; if the FIFO is full and no pop occurs in the same cycle, drop the byte and pulse overrun.
- A discarded byte never reaches TXd.
- FIFO:
  - Circular buffer with wrapping read/write pointers; fifo_level is registered.
  - Simultaneous push and pop: both take effect and level is unchanged. This holds when full: the push is accepted.
  - Pop never occurs when empty.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START when fifo_level ≠ 0 and tx_hold = 0. The byte is popped in that same cycle.
  - Each bit lasts exactly CLKS_PER_BIT cycles. Order is start (0), data LSB first, parity if enabled, then STOP_BITS stop bits (1).
  - After the last stop bit the FSM returns to IDLE for exactly one cycle before any next frame.
- Frame length on TXd: 1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS bits.

## Timing
- Push occurs on the clk edge ending the stop-sample cycle (call it edge E). fifo_level reflects the push after E.
- Echo latency: TX sees non-empty in the cycle after E and pops it. TXd falls on edge E+2.
- Error and overrun pulses are registered: high for exactly the one cycle following edge E.
- tx_hold is sampled only in TX IDLE. Asserting it mid-frame has no effect until the frame ends.
- Inter-frame gap on TXd with a non-empty FIFO: the last stop bit, then exactly 1 extra clk high.
- All outputs are registered; no combinational path from RXd or tx_hold to any output.

## Test plan
- Basic echo: CLKS_PER_BIT=16, 8N1; RXd sends 0xA5. Required response: fifo_level pulses 1 then 0. TXd carries start, bits 1,0,1,0,0,1,0,1, stop, with the start edge 2 clks after the stop-sample edge.
- Even parity, DATA_BITS=7: send 0x07 with parity 0 (wrong). Required response: parity_err high for 1 cycle, fifo_level stays 0, TXd stays 1. Send 0x07 with parity 1: echoed with parity bit 1.
- Framing: send 0x3C with stop bit 0. Required response: frame_err 1-cycle pulse, no echo. A following valid 0x3C is echoed normally.
- Overrun, FIFO_DEPTH=4: hold tx_hold=1 and send 0x01..0x06. Required response: fifo_level reaches 4, overrun pulses on bytes 5 and 6. After releasing tx_hold, TXd emits 0x01..0x04 with 1-clk gaps.
- Glitch: RXd low for 4 clks at CLKS_PER_BIT=16. Required response: RX returns to IDLE, no error pulses, fifo_level 0.
- Reset mid-frame: assert rst halfway through the TX data bits of 0xFF. Required response: TXd=1 and fifo_level=0 immediately, with no clk edge needed. After release, TXd stays idle-high with no residual frame.
